// File: rtl/hydra_pkg.sv
// Hydra shared constants: memory word and strand index widths plus the WS2811
// bit timing used by both the strand driver (TX) and the strand receiver (RX).
package hydra_pkg;

  localparam int MEM_DATA_WIDTH     = 24;
  localparam int STRAND_PARAM_WIDTH = 16;

  // WS2811 800 kHz timing in 50 MHz clocks; TX and RX must agree on these.
  localparam int WS_MIN_HIGH     = 5;
  localparam int WS_BIT_THRESH   = 30;
  localparam int WS_MAX_HIGH     = 50;
  localparam int WS_LATCH_CYCLES = 2500;

  localparam int WS_HIGH_CNT_W = $clog2(WS_MAX_HIGH + 2);
  localparam int WS_LOW_CNT_W  = $clog2(WS_LATCH_CYCLES + 1);
  localparam int WS_BIT_CNT_W  = $clog2(MEM_DATA_WIDTH);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; both stages reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ws2811_rx.sv
// WS2811 NRZ receiver: times each synchronised high pulse, assembles 24-bit pixel
// words MSB first and detects the latch gap. WS2811_RX_ERR_STATS_EN adds err_count.
module ws2811_rx
  import hydra_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          din,
  output logic [MEM_DATA_WIDTH-1:0]     pixel_data,
  output logic                          pixel_valid,
  output logic [STRAND_PARAM_WIDTH-1:0] pixel_idx,
  output logic                          frame_done,
  output logic                          rx_err
`ifdef WS2811_RX_ERR_STATS_EN
  ,
  output logic [15:0]                   err_count
`endif
);

  typedef enum logic [1:0] {
    ST_WAIT_LATCH,
    ST_LOW,
    ST_HIGH
  } state_e;

  localparam logic [WS_HIGH_CNT_W-1:0] HIGH_MIN    = WS_HIGH_CNT_W'(WS_MIN_HIGH);
  localparam logic [WS_HIGH_CNT_W-1:0] HIGH_THRESH = WS_HIGH_CNT_W'(WS_BIT_THRESH);
  localparam logic [WS_HIGH_CNT_W-1:0] HIGH_MAX    = WS_HIGH_CNT_W'(WS_MAX_HIGH);
  localparam logic [WS_HIGH_CNT_W-1:0] HIGH_ONE    = WS_HIGH_CNT_W'(1);
  localparam logic [WS_LOW_CNT_W-1:0]  LOW_LATCH   = WS_LOW_CNT_W'(WS_LATCH_CYCLES);
  localparam logic [WS_LOW_CNT_W-1:0]  LOW_ONE     = WS_LOW_CNT_W'(1);
  localparam logic [WS_BIT_CNT_W-1:0]  BIT_LAST    = WS_BIT_CNT_W'(MEM_DATA_WIDTH - 1);
  localparam logic [WS_BIT_CNT_W-1:0]  BIT_ONE     = WS_BIT_CNT_W'(1);
  localparam logic [STRAND_PARAM_WIDTH-1:0] IDX_ONE = STRAND_PARAM_WIDTH'(1);

  logic din_sync;
  logic rise;

  state_e                        state_q, state_d;
  logic                          din_prev_q, din_prev_d;
  logic [WS_HIGH_CNT_W-1:0]      high_cnt_q, high_cnt_d;
  logic [WS_LOW_CNT_W-1:0]       low_cnt_q, low_cnt_d;
  logic [WS_BIT_CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [MEM_DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [MEM_DATA_WIDTH-1:0]     pixel_data_q, pixel_data_d;
  logic [STRAND_PARAM_WIDTH-1:0] pixel_idx_q, pixel_idx_d;
  logic                          pixel_valid_q, pixel_valid_d;
  logic                          frame_done_q, frame_done_d;
  logic                          rx_err_q, rx_err_d;

  logic [WS_LOW_CNT_W-1:0]   low_inc;
  logic [MEM_DATA_WIDTH-1:0] shift_next;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din),
    .q     (din_sync)
  );

  assign rise       = din_sync & ~din_prev_q;
  assign low_inc    = (low_cnt_q == LOW_LATCH) ? low_cnt_q : low_cnt_q + LOW_ONE;
  assign shift_next = {shift_q[MEM_DATA_WIDTH-2:0], (high_cnt_q > HIGH_THRESH)};

  // The index advances the clock after a word strobe so it names that word while valid.
  always_comb begin
    state_d       = state_q;
    din_prev_d    = din_sync;
    high_cnt_d    = high_cnt_q;
    low_cnt_d     = low_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    pixel_data_d  = pixel_data_q;
    pixel_idx_d   = pixel_valid_q ? pixel_idx_q + IDX_ONE : pixel_idx_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    rx_err_d      = 1'b0;

    case (state_q)
      ST_WAIT_LATCH: begin
        if (din_sync) begin
          low_cnt_d = '0;
        end else begin
          low_cnt_d = low_inc;
          if (low_inc == LOW_LATCH) begin
            state_d     = ST_LOW;
            pixel_idx_d = '0;
          end
        end
      end

      ST_LOW: begin
        if (rise) begin
          state_d    = ST_HIGH;
          high_cnt_d = HIGH_ONE;
        end else if (!din_sync) begin
          low_cnt_d = low_inc;
          if (low_cnt_q != LOW_LATCH && low_inc == LOW_LATCH) begin
            frame_done_d = (bit_cnt_q != '0) || (pixel_idx_q != '0);
            rx_err_d     = (bit_cnt_q != '0);
            bit_cnt_d    = '0;
            shift_d      = '0;
            pixel_idx_d  = '0;
          end
        end
      end

      ST_HIGH: begin
        if (din_sync) begin
          if (high_cnt_q >= HIGH_MAX) begin
            rx_err_d  = 1'b1;
            bit_cnt_d = '0;
            shift_d   = '0;
            low_cnt_d = '0;
            state_d   = ST_WAIT_LATCH;
          end else begin
            high_cnt_d = high_cnt_q + HIGH_ONE;
          end
        end else if (high_cnt_q < HIGH_MIN) begin
          rx_err_d  = 1'b1;
          bit_cnt_d = '0;
          shift_d   = '0;
          low_cnt_d = LOW_ONE;
          state_d   = ST_WAIT_LATCH;
        end else begin
          shift_d   = shift_next;
          low_cnt_d = LOW_ONE;
          state_d   = ST_LOW;
          if (bit_cnt_q == BIT_LAST) begin
            pixel_data_d  = shift_next;
            pixel_valid_d = 1'b1;
            bit_cnt_d     = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end
      end

      default: state_d = ST_WAIT_LATCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT_LATCH;
      din_prev_q    <= 1'b0;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      pixel_data_q  <= '0;
      pixel_idx_q   <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      rx_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      din_prev_q    <= din_prev_d;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      pixel_data_q  <= pixel_data_d;
      pixel_idx_q   <= pixel_idx_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
      rx_err_q      <= rx_err_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_idx   = pixel_idx_q;
  assign frame_done  = frame_done_q;
  assign rx_err      = rx_err_q;

`ifdef WS2811_RX_ERR_STATS_EN
  logic [15:0] err_count_q, err_count_d;

  // Counts alongside the strobe so the total is current in the same clock.
  always_comb begin
    err_count_d = err_count_q;
    if (rx_err_d && err_count_q != 16'hFFFF) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_ws2811_rx.sv
// Directed bench for ws2811_rx: sends WS2811 bit streams and checks pixel words,
// frame/latch strobes, timing errors and synchronous reset behaviour.
module tb_ws2811_rx;

  logic        clk;
  logic        rst_n;
  logic        din;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [15:0] pixel_idx;
  logic        frame_done;
  logic        rx_err;
`ifdef WS2811_RX_ERR_STATS_EN
  logic [15:0] err_count;
`endif

  int total;
  int bad;
  int cyc;
  int pv_cnt, fd_cnt, err_cnt, fd_err_same, fd_pv_same;
  int last_pv_cyc, first_err_cyc, last_fall_cyc, rise_cyc;
  logic [23:0] pv_data[$];
  logic [15:0] pv_idx[$];

  ws2811_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_idx   (pixel_idx),
    .frame_done  (frame_done),
    .rx_err      (rx_err)
`ifdef WS2811_RX_ERR_STATS_EN
    ,
    .err_count   (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clearLog();
    pv_cnt = 0; fd_cnt = 0; err_cnt = 0; fd_err_same = 0; fd_pv_same = 0;
    last_pv_cyc = -1; first_err_cyc = -1;
    pv_data.delete();
    pv_idx.delete();
  endtask

  // Advance n clocks, sampling 1 ns after each rising edge and logging strobes.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (pixel_valid) begin
        pv_cnt++;
        last_pv_cyc = cyc;
        pv_data.push_back(pixel_data);
        pv_idx.push_back(pixel_idx);
      end
      if (frame_done) fd_cnt++;
      if (rx_err) begin
        if (err_cnt == 0) first_err_cyc = cyc;
        err_cnt++;
      end
      if (frame_done && rx_err) fd_err_same++;
      if (frame_done && pixel_valid) fd_pv_same++;
    end
  endtask

  // One bit: 20 clks high for 0, 40 clks high for 1, 62-clk period.
  task automatic sendBit(input logic b);
    din = 1'b1;
    step(b ? 40 : 20);
    din = 1'b0;
    last_fall_cyc = cyc;
    step(b ? 22 : 42);
  endtask

  task automatic applyStimulus(input logic [23:0] word, input int nbits);
    for (int i = 23; i > 23 - nbits; i--) begin
      sendBit(word[i]);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; last_fall_cyc = 0; rise_cyc = 0;
    din = 1'b0;
    rst_n = 1'b0;
    clearLog();

    // Reset state.
    step(3);
    checkOutput("rst_pixel_data", pixel_data, 24'h0);
    checkOutput("rst_pixel_valid", pixel_valid, 1'b0);
    checkOutput("rst_pixel_idx", pixel_idx, 16'h0);
    checkOutput("rst_frame_done", frame_done, 1'b0);
    checkOutput("rst_rx_err", rx_err, 1'b0);
`ifdef WS2811_RX_ERR_STATS_EN
    checkOutput("rst_err_count", err_count, 16'h0);
`endif
    rst_n = 1'b1;

    // Test 1: initial latch gap, then one word; strobe 3 clks after the last raw fall.
    $display("[TB] test 1: single word");
    step(2505);
    checkOutput("t1_gap_no_frame_done", fd_cnt, 0);
    checkOutput("t1_gap_no_err", err_cnt, 0);
    clearLog();
    applyStimulus(24'hA5C33C, 24);
    checkOutput("t1_pv_count", pv_cnt, 1);
    checkOutput("t1_pv_data", pv_data[0], 24'hA5C33C);
    checkOutput("t1_pv_idx", pv_idx[0], 16'h0);
    checkOutput("t1_latency", last_pv_cyc - last_fall_cyc, 3);
    checkOutput("t1_data_held", pixel_data, 24'hA5C33C);
    checkOutput("t1_idx_advanced", pixel_idx, 16'h1);

    // Test 2: three words in a fresh frame, latch, then index restarts.
    $display("[TB] test 2: multi-word frame");
    step(2510);
    clearLog();
    applyStimulus(24'h000001, 24);
    applyStimulus(24'hFFFFFF, 24);
    applyStimulus(24'h123456, 24);
    step(2510);
    checkOutput("t2_pv_count", pv_cnt, 3);
    checkOutput("t2_data0", pv_data[0], 24'h000001);
    checkOutput("t2_data1", pv_data[1], 24'hFFFFFF);
    checkOutput("t2_data2", pv_data[2], 24'h123456);
    checkOutput("t2_idx0", pv_idx[0], 16'd0);
    checkOutput("t2_idx1", pv_idx[1], 16'd1);
    checkOutput("t2_idx2", pv_idx[2], 16'd2);
    checkOutput("t2_frame_done_once", fd_cnt, 1);
    checkOutput("t2_no_err", err_cnt, 0);
    checkOutput("t2_no_fd_pv_overlap", fd_pv_same, 0);
    checkOutput("t2_idx_cleared", pixel_idx, 16'h0);
    clearLog();
    applyStimulus(24'h0F0F0F, 24);
    checkOutput("t2_next_frame_idx", pv_idx[0], 16'd0);
    checkOutput("t2_next_frame_data", pv_data[0], 24'h0F0F0F);

    // Test 3: glitch mid-word drops the word until a full gap and fresh bits.
    $display("[TB] test 3: glitch");
    step(2510);
    clearLog();
    applyStimulus(24'hABCDEF, 10);
    din = 1'b1;
    step(3);
    din = 1'b0;
    step(59);
    checkOutput("t3_glitch_err", err_cnt, 1);
    applyStimulus(24'h777777, 24);
    checkOutput("t3_no_pv_without_gap", pv_cnt, 0);
    step(2510);
    checkOutput("t3_gap_no_frame_done", fd_cnt, 0);
    applyStimulus(24'h5A5A5A, 24);
    checkOutput("t3_recover_pv_count", pv_cnt, 1);
    checkOutput("t3_recover_data", pv_data[0], 24'h5A5A5A);
    checkOutput("t3_recover_idx", pv_idx[0], 16'd0);

    // Test 4: stuck high; 51st synced-high clk is 2 sync clks after the raw rise, so flag at +53.
    $display("[TB] test 4: stuck high");
    clearLog();
    rise_cyc = cyc;
    din = 1'b1;
    step(60);
    checkOutput("t4_err_before_fall", err_cnt, 1);
    checkOutput("t4_err_cycle", first_err_cyc - rise_cyc, 53);
    din = 1'b0;
    step(60);
    checkOutput("t4_no_err_on_fall", err_cnt, 1);
    applyStimulus(24'h333333, 24);
    checkOutput("t4_wait_latch_no_pv", pv_cnt, 0);
    step(2510);
    applyStimulus(24'hC0FFEE, 24);
    checkOutput("t4_recover_data", pv_data[0], 24'hC0FFEE);
    checkOutput("t4_recover_idx", pv_idx[0], 16'd0);

    // Test 5: partial word at the latch gives frame_done and rx_err together.
    $display("[TB] test 5: partial word at latch");
    step(2510);
    clearLog();
    applyStimulus(24'h3C3C3C, 10);
    step(2510);
    checkOutput("t5_frame_done", fd_cnt, 1);
    checkOutput("t5_rx_err", err_cnt, 1);
    checkOutput("t5_same_clk", fd_err_same, 1);
    checkOutput("t5_no_pv", pv_cnt, 0);
`ifdef WS2811_RX_ERR_STATS_EN
    checkOutput("t5_err_count", err_count, 16'd3);
`endif

    // Test 6: reset mid-word, then bits without a gap are ignored.
    $display("[TB] test 6: reset mid-frame");
    clearLog();
    applyStimulus(24'h9999FF, 12);
    rst_n = 1'b0;
    step(1);
    checkOutput("t6_rst_pixel_data", pixel_data, 24'h0);
    checkOutput("t6_rst_pixel_idx", pixel_idx, 16'h0);
    checkOutput("t6_rst_strobes", {pixel_valid, frame_done, rx_err}, 3'b000);
`ifdef WS2811_RX_ERR_STATS_EN
    checkOutput("t6_rst_err_count", err_count, 16'h0);
`endif
    rst_n = 1'b1;
    clearLog();
    applyStimulus(24'h246810, 24);
    checkOutput("t6_no_pv_after_reset", pv_cnt, 0);
    checkOutput("t6_no_err_after_reset", err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
